// File: rtl/id_ex_issue_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_issue_reg_if
// Bundle of signals between the ID stage / stall controller and the ID->EX
// issue register.
//
// ID-side inputs to the register:
//   flush_i, flush_cause_i, stall_self_i, stall_next_i,
//   keep_mask_i[LANES], in_valid_i[LANES], in_payload_i[LANES*PAYLOAD_W],
//   in_side_i[SIDE_W], ds_flag_i
//
// Register outputs towards EX:
//   out_valid_o[LANES], out_payload_o[LANES*PAYLOAD_W], out_side_o[SIDE_W],
//   ds_flag_o, bubble_cnt_o[CNT_W], flush_cnt_o[CNT_W]
//
// The master modport is the driver's view (ID / stall control / bench).
// The slave modport is the register's view.
// ---------------------------------------------------------------------------
interface id_ex_issue_reg_if #(
    parameter int LANES     = 2,
    parameter int PAYLOAD_W = 160,
    parameter int SIDE_W    = 33,
    parameter int CNT_W     = 16
);
    logic                         flush_i;
    logic                         flush_cause_i;
    logic                         stall_self_i;
    logic                         stall_next_i;
    logic [LANES-1:0]             keep_mask_i;
    logic [LANES-1:0]             in_valid_i;
    logic [LANES*PAYLOAD_W-1:0]   in_payload_i;
    logic [SIDE_W-1:0]            in_side_i;
    logic                         ds_flag_i;

    logic [LANES-1:0]             out_valid_o;
    logic [LANES*PAYLOAD_W-1:0]   out_payload_o;
    logic [SIDE_W-1:0]            out_side_o;
    logic                         ds_flag_o;
    logic [CNT_W-1:0]             bubble_cnt_o;
    logic [CNT_W-1:0]             flush_cnt_o;

    modport master (
        output flush_i, flush_cause_i, stall_self_i, stall_next_i,
               keep_mask_i, in_valid_i, in_payload_i, in_side_i, ds_flag_i,
        input  out_valid_o, out_payload_o, out_side_o, ds_flag_o,
               bubble_cnt_o, flush_cnt_o
    );

    modport slave (
        input  flush_i, flush_cause_i, stall_self_i, stall_next_i,
               keep_mask_i, in_valid_i, in_payload_i, in_side_i, ds_flag_i,
        output out_valid_o, out_payload_o, out_side_o, ds_flag_o,
               bubble_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/id_ex_issue_reg.sv
// ---------------------------------------------------------------------------
// id_ex_issue_reg
// Parametrised ID->EX pipeline register for the multi-issue core.
// LANES generic payload slots with per-lane valid bits, a shared bundle
// sideband (branch predictor info) and the next_inst_in_delayslot flag.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, clears all state and counters
//   bus  - id_ex_issue_reg_if.slave: flush/stall controls, keep mask,
//          incoming bundle, registered outputs and the two event counters
//
// Per-cycle event priority:
//   reset > exception flush > mispredict flush while both stages stalled
//   (hold) > mispredict flush (selective keep) > bubble > load > hold.
// All outputs come straight from flops; there is no input-to-output path.
// ---------------------------------------------------------------------------
module id_ex_issue_reg #(
    parameter int LANES        = 2,
    parameter int PAYLOAD_W    = 160,
    parameter int SIDE_W       = 33,
    parameter bit ZERO_INVALID = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_ex_issue_reg_if.slave  bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [LANES-1:0]           valid_reg;
    logic [LANES*PAYLOAD_W-1:0] payload_reg;
    logic [SIDE_W-1:0]          side_reg;
    logic                       ds_reg;
    logic [CNT_W-1:0]           bubble_cnt_reg;
    logic [CNT_W-1:0]           flush_cnt_reg;

    logic [LANES-1:0]           valid_next;
    logic [LANES*PAYLOAD_W-1:0] payload_next;
    logic [SIDE_W-1:0]          side_next;
    logic                       ds_next;
    logic [CNT_W-1:0]           bubble_cnt_next;
    logic [CNT_W-1:0]           flush_cnt_next;

    // ------------------------------------------------------------------
    // Event decode (mutually exclusive, reset handled in the flop block)
    // ------------------------------------------------------------------
    logic flush_exc;
    logic flush_bp;
    logic bubble;
    logic load;
    logic [LANES-1:0] lane_keep;

    assign flush_exc = bus.flush_i & bus.flush_cause_i;
    // A mispredict flush while both ID and EX are stalled must not apply:
    // EX is still holding the branch, so our contents are still needed.
    assign flush_bp  = bus.flush_i & ~bus.flush_cause_i
                     & ~(bus.stall_self_i & bus.stall_next_i);
    assign bubble    = ~bus.flush_i & bus.stall_self_i & ~bus.stall_next_i;
    // stall_self=0 with stall_next=1 is illegal and treated as a load.
    assign load      = ~bus.flush_i & ~bus.stall_self_i;

    // ------------------------------------------------------------------
    // Per-lane next state
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [PAYLOAD_W-1:0] lane_in;
            logic [PAYLOAD_W-1:0] lane_load;
            logic [PAYLOAD_W-1:0] lane_hold;

            assign lane_in   = bus.in_payload_i[gi*PAYLOAD_W +: PAYLOAD_W];
            assign lane_hold = payload_reg[gi*PAYLOAD_W +: PAYLOAD_W];
            assign lane_keep[gi] = bus.in_valid_i[gi] & bus.keep_mask_i[gi];

            // Zeroing invalid lanes keeps stale operands from toggling EX logic.
            assign lane_load = (ZERO_INVALID && !bus.in_valid_i[gi])
                               ? '0 : lane_in;

            assign valid_next[gi] =
                flush_exc ? 1'b0 :
                flush_bp  ? lane_keep[gi] :
                bubble    ? 1'b0 :
                load      ? bus.in_valid_i[gi] :
                            valid_reg[gi];

            // A kept lane is always valid, so its raw payload is already clean.
            assign payload_next[gi*PAYLOAD_W +: PAYLOAD_W] =
                flush_exc ? '0 :
                flush_bp  ? (lane_keep[gi] ? lane_in : '0) :
                bubble    ? '0 :
                load      ? lane_load :
                            lane_hold;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Bundle-wide next state
    // ------------------------------------------------------------------
    assign side_next =
        (flush_exc | flush_bp | bubble) ? '0 :
        load                            ? bus.in_side_i :
                                          side_reg;

    // The delay-slot flag survives a bubble, and survives a mispredict
    // flush only if some younger lane (the delay slot) was kept.
    assign ds_next =
        flush_exc ? 1'b0 :
        flush_bp  ? ((|lane_keep) & bus.ds_flag_i) :
        bubble    ? bus.ds_flag_i :
        load      ? bus.ds_flag_i :
                    ds_reg;

    // Saturating event counters.
    assign bubble_cnt_next =
        (bubble && (bubble_cnt_reg != {CNT_W{1'b1}}))
        ? bubble_cnt_reg + CNT_W'(1) : bubble_cnt_reg;

    assign flush_cnt_next =
        ((flush_exc | flush_bp) && (flush_cnt_reg != {CNT_W{1'b1}}))
        ? flush_cnt_reg + CNT_W'(1) : flush_cnt_reg;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg      <= '0;
            payload_reg    <= '0;
            side_reg       <= '0;
            ds_reg         <= 1'b0;
            bubble_cnt_reg <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            valid_reg      <= valid_next;
            payload_reg    <= payload_next;
            side_reg       <= side_next;
            ds_reg         <= ds_next;
            bubble_cnt_reg <= bubble_cnt_next;
            flush_cnt_reg  <= flush_cnt_next;
        end
    end

    assign bus.out_valid_o   = valid_reg;
    assign bus.out_payload_o = payload_reg;
    assign bus.out_side_o    = side_reg;
    assign bus.ds_flag_o     = ds_reg;
    assign bus.bubble_cnt_o  = bubble_cnt_reg;
    assign bus.flush_cnt_o   = flush_cnt_reg;

    // The stall controller must never stall EX while ID advances.
    ap_legal_stall: assert property (@(posedge clk) disable iff (rst)
        !(!bus.stall_self_i && bus.stall_next_i));

endmodule
